reduction_sequencer: RTL
========================

# reduction_sequencer

Streaming reduction controller for the combinational adder tree. It accepts a vector as a sequence of `Elements`-wide beats over a valid/ready handshake and reduces each beat through an internal `AdderTree`. Per-beat partial sums are accumulated into a wide signed register, and the total is presented on a held output handshake. It sits between a vector producer (e.g. a layer's activation/product stream) and the consumer of scalar dot-product or sum results.

## Interface
- `Elements`, 8: lanes per beat; power of two, ≥2; passed to the internal `AdderTree`.
- `AccWidth`, 16: accumulator and result width, signed; ≥9.
- `CountWidth`, 8: beat-counter width.

- `clk_in`  input  1  sole clock; all state changes on the rising edge.
- `rst_n_in`  input  1  asynchronous, active-low reset.
- `clear_in`  input  1  synchronous abort; returns the block to IDLE.
- `in_data`  input  [Elements-1:0][7:0]  beat lanes.
- `in_valid`  input  1  beat present.
- `in_last`  input  1  final beat of the vector; qualified by `in_valid`.
- `in_ready`  output  1  block can accept a beat.
- `out_data`  output  AccWidth  signed reduction result.
- `out_beats`  output  CountWidth  number of beats in the result.
- `out_overflow`  output  1  signed accumulator overflow occurred during this vector.
- `out_valid`  output  1  result present.
- `out_ready`  input  1  consumer accepts the result.

## Operation
- Partial sum `p` is the `AdderTree` output over `in_data`: 8-bit, modulo 256, interpreted as signed.
- `p` is sign-extended to `AccWidth` before accumulation. The accumulator wraps modulo 2^AccWidth.
- `out_overflow` is sticky per vector. It is set when an add's operands share a sign and the result's sign differs.
- A beat is accepted when `in_valid && in_ready`.
- FSM states:
  - IDLE: `in_ready`=1. On acceptance: acc←sext(p), beats←1, ovf←0. Next state is DONE if `in_last`, otherwise ACCUM.
  - ACCUM: `in_ready`=1. On acceptance: acc←acc+sext(p), beats←beats+1 (saturates at all-ones), ovf←ovf|overflow. Next state is DONE if `in_last`.
  - DONE: `in_ready`=0 and `out_valid`=1. `out_data`/`out_beats`/`out_overflow` hold registered values and do not change while `out_valid`=1. On `out_ready`=1 the next state is IDLE.
- `clear_in`=1 in any state: next state IDLE; acc, beats and ovf become 0; any beat on that edge is dropped. `clear_in` has priority over both acceptance and `out_ready`.
- `in_data` and `in_last` are ignored when `in_valid`=0.

## Timing
- Reset (async assert, any state): state IDLE, acc=0, beats=0, ovf=0. Outputs during reset: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_beats`=0, `out_overflow`=0.
- `in_ready` is 1 from the first edge after reset deassertion while in IDLE/ACCUM. It is a function of state only and never combinationally depends on `in_valid` or `out_ready`.
- Latency: the last beat is accepted at edge N, and `out_valid` is high from edge N to the edge where `out_ready`=1.
- `out_valid` deasserts on the edge after it is high with `out_ready`=1. `in_ready` reasserts on that same edge.
- There is no overlap between vectors: the first beat of the next vector can be accepted at the earliest one cycle after the result handshake.
- Throughput: one beat per cycle in IDLE/ACCUM. A K-beat vector with `out_ready` tied high occupies K+1 cycles.
- Reset asserted mid-ACCUM or mid-DONE discards the partial result with no `out_valid` pulse.
- An IDLE beat with `in_last`=1 is a valid 1-beat vector.

## Test plan
- Elements=4: three beats of {1,2,3,4}, `in_last` on the third, `out_ready`=1 → `out_valid` 1 cycle after the third beat; `out_data`=30, `out_beats`=3, `out_overflow`=0.
- Lane wrap: one beat {100,100,0,0} with `in_last` → `out_data`=-56 (16'hFFC8), `out_beats`=1.
- Backpressure: complete a vector with `out_ready`=0 for 5 cycles → `out_valid`/`out_data` stable and `in_ready`=0 throughout; `out_ready`=1 → IDLE next edge with `in_ready`=1.
- Overflow with AccWidth=10: five beats of {127,0,0,0} → `out_data`=-389 (635−1024), `out_overflow`=1. The next vector {1,0,0,0} gives `out_overflow`=0.
- Abort: two beats accepted, then `clear_in`=1 on an edge with `in_valid`=1 → no result; the next single beat {5,0,0,0} with `in_last` gives `out_data`=5, `out_beats`=1.
- Reset mid-ACCUM: drop `rst_n_in` after two beats → all outputs 0 immediately; after release, a new 1-beat vector {2,2,2,2} gives 8.

Source files
------------

// File: rtl/reduction_sequencer.sv
// Streaming sum-reduction: Elements-lane beats summed by an adder tree, accumulated into a signed register.
// Latency: result valid on the edge that accepts the last beat; held until out_ready.
// Backpressure: in_ready drops while a result waits; one vector in flight, no overlap.

module adder_tree #(
    parameter int Elements = 8
) (
    input  logic [Elements-1:0][7:0] lanes,
    output logic [7:0]               sum
);
    localparam int Levels = $clog2(Elements);

    logic [Elements-1:0][7:0] node;

    // Pairwise halving per level; lane sums wrap modulo 256.
    always_comb begin
        node = lanes;
        for (int lvl = 0; lvl < Levels; lvl++) begin
            for (int j = 0; j < Elements / 2; j++) begin
                if (j < (Elements >> (lvl + 1))) begin
                    node[j] = node[2*j] + node[2*j+1];
                end
            end
        end
        sum = node[0];
    end
endmodule

module reduction_sequencer #(
    parameter int Elements   = 8,
    parameter int AccWidth   = 16,
    parameter int CountWidth = 8
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         clear_in,
    input  logic [Elements-1:0][7:0]     in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic [AccWidth-1:0]          out_data,
    output logic [CountWidth-1:0]        out_beats,
    output logic                         out_overflow,
    output logic                         out_valid,
    input  logic                         out_ready
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [AccWidth-1:0]   acc, acc_nxt;
    logic [CountWidth-1:0] beats, beats_nxt;
    logic                  ovf, ovf_nxt;
    logic                  live;

    logic [7:0]            part_sum;
    logic [AccWidth-1:0]   part_ext;
    logic [AccWidth-1:0]   acc_sum;
    logic                  add_ovf;
    logic                  accept;

    adder_tree #(.Elements(Elements)) u_tree (
        .lanes (in_data),
        .sum   (part_sum)
    );

    assign part_ext = {{(AccWidth-8){part_sum[7]}}, part_sum};
    assign acc_sum  = acc + part_ext;
    assign add_ovf  = (acc[AccWidth-1] == part_ext[AccWidth-1]) &&
                      (acc_sum[AccWidth-1] != acc[AccWidth-1]);

    // live keeps in_ready low until the first edge after reset release.
    assign in_ready     = live && (state != DONE);
    assign accept       = in_valid && in_ready;
    assign out_valid    = (state == DONE);
    assign out_data     = acc;
    assign out_beats    = beats;
    assign out_overflow = ovf;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
            acc   <= '0;
            beats <= '0;
            ovf   <= 1'b0;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            beats <= beats_nxt;
            ovf   <= ovf_nxt;
            live  <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        beats_nxt = beats;
        ovf_nxt   = ovf;
        case (state)
            IDLE: begin
                if (accept) begin
                    acc_nxt   = part_ext;
                    beats_nxt = CountWidth'(1);
                    ovf_nxt   = 1'b0;
                    state_nxt = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_nxt   = acc_sum;
                    beats_nxt = (&beats) ? beats : beats + CountWidth'(1);
                    ovf_nxt   = ovf | add_ovf;
                    if (in_last) state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Abort outranks both acceptance and the result handshake.
        if (clear_in) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            beats_nxt = '0;
            ovf_nxt   = 1'b0;
        end
    end
endmodule
